instr_encoder: RTL and testbench

Instruction encoder and program loader for the single-cycle MIPS core. It accepts symbolic instruction requests (operation class plus register, immediate and target fields) over a valid/ready handshake. It packs each request into a 32-bit MIPS word using the same opcode map that the main controller decodes. It then streams the word, with a sequential instruction-memory address, to the imem write port through a one-entry registered output stage.

---
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder.sv | 150 +++++++++++++++
 tb/tb_instr_encoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/word bus between a program source and the instruction encoder.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry the handshakes on each side.
interface instr_encoder_if #(parameter int ADDR_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_instr;
    logic              full;
    logic              err;

    // Program source side: issues requests and acts as the imem write port.
    modport master (
        output in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target, out_ready,
        input  in_ready, out_valid, out_addr, out_instr, full, err
    );

    // Encoder side.
    modport slave (
        input  in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target, out_ready,
        output in_ready, out_valid, out_addr, out_instr, full, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic MIPS requests into 32-bit words and streams them with sequential imem addresses.
// Latency: one cycle from accept to out_valid; one word per cycle when out_ready stays high.
// Backpressure: a held word blocks new accepts until handed off; capacity reached blocks until clear.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    instr_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] addrPtr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] outAddr;
    logic [31:0]       outInstr;
    logic [31:0]       encWord;
    logic              errQ;
    logic              outValid;
    logic              fullFlag;
    logic              capReached;
    logic              legalOp;
    logic              inReady;
    logic              accept;
    logic              legalAcc;
    logic              illegalAcc;

    // count has one extra bit so the top bit alone says every address has been written
    assign capReached = count[ADDR_W];
    assign legalOp    = (bus.op_sel <= 4'd9);
    // capReached also blocks accepts while the last word is still waiting in HOLD
    assign inReady    = !clear && !fullFlag && !capReached && (!outValid || bus.out_ready);
    assign accept     = bus.in_valid && inReady;
    assign legalAcc   = accept && legalOp;
    assign illegalAcc = accept && !legalOp;

    // Pack the request using the controller's opcode map; unused fields never reach the word.
    always_comb begin
        encWord = '0;
        case (bus.op_sel)
            4'd0:    encWord = {6'b000000, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
            4'd1:    encWord = {6'b000010, bus.target};
            4'd2:    encWord = {6'b000100, bus.rs, bus.rt, bus.imm};
            4'd3:    encWord = {6'b000101, bus.rs, bus.rt, bus.imm};
            4'd4:    encWord = {6'b100011, bus.rs, bus.rt, bus.imm};
            4'd5:    encWord = {6'b101011, bus.rs, bus.rt, bus.imm};
            4'd6:    encWord = {6'b001000, bus.rs, bus.rt, bus.imm};
            4'd7:    encWord = {6'b001100, bus.rs, bus.rt, bus.imm};
            4'd8:    encWord = {6'b001101, bus.rs, bus.rt, bus.imm};
            4'd9:    encWord = {6'b001010, bus.rs, bus.rt, bus.imm};
            default: encWord = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // Next state: clear only empties the stage once any held word has been delivered.
    always_comb begin
        nextState = state;
        if (clear) begin
            case (state)
                HOLD:    nextState = bus.out_ready ? EMPTY : HOLD;
                default: nextState = EMPTY;
            endcase
        end else begin
            case (state)
                EMPTY: begin
                    if (legalAcc) nextState = HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        if (legalAcc)        nextState = HOLD;
                        else if (capReached) nextState = FULL;
                        else                 nextState = EMPTY;
                    end
                end
                FULL:    nextState = FULL;
                default: nextState = EMPTY;
            endcase
        end
    end

    // Outputs decoded from state.
    always_comb begin
        outValid = 1'b0;
        fullFlag = 1'b0;
        case (state)
            HOLD:    outValid = 1'b1;
            FULL:    fullFlag = 1'b1;
            default: ;
        endcase
    end

    // Address pointer and word count; illegal requests leave both untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrPtr <= '0;
            count   <= '0;
        end else if (clear) begin
            addrPtr <= '0;
            count   <= '0;
        end else if (legalAcc) begin
            addrPtr <= addrPtr + {{(ADDR_W-1){1'b0}}, 1'b1};
            count   <= count + {{ADDR_W{1'b0}}, 1'b1};
        end
    end

    // Output word register; only a legal accept replaces it, so it holds steady under stall and clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outAddr  <= '0;
            outInstr <= '0;
        end else if (legalAcc) begin
            outAddr  <= addrPtr;
            outInstr <= encWord;
        end
    end

    // One-cycle error pulse for each consumed illegal request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errQ <= 1'b0;
        end else begin
            errQ <= illegalAcc;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_addr  = outAddr;
    assign bus.out_instr = outInstr;
    assign bus.full      = fullFlag;
    assign bus.err       = errQ;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver models expected acceptance, monitor checks delivered words.
// Latency: words are expected the cycle after the model accepts them.
// Backpressure: out_ready is driven directed and randomized.
module tb_instr_encoder;
    localparam int AW  = 3;
    localparam int CAP = 1 << AW;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } req_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   instr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t expQ[$];

    // Reference model state, kept at the level of "words written / word waiting".
    int mPtr     = 0;
    int mCount   = 0;
    bit mPending = 1'b0;
    bit mFull    = 1'b0;
    bit mErr     = 1'b0;

    localparam bit [5:0] OPC [0:9] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h23,
                                       6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0A};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] encode(input req_t r);
        logic [31:0] w;
        if (r.op == 4'd0)      w = (32'(r.rs) << 21) | (32'(r.rt) << 16) | (32'(r.rd) << 11)
                                   | (32'(r.shamt) << 6) | 32'(r.funct);
        else if (r.op == 4'd1) w = (32'(OPC[1]) << 26) | 32'(r.target);
        else                   w = (32'(OPC[r.op]) << 26) | (32'(r.rs) << 21)
                                   | (32'(r.rt) << 16) | 32'(r.imm);
        return w;
    endfunction

    function automatic req_t mkRand(input logic [3:0] op);
        req_t r;
        r.op     = op;
        r.rs     = 5'($urandom);
        r.rt     = 5'($urandom);
        r.rd     = 5'($urandom);
        r.shamt  = 5'($urandom);
        r.funct  = 6'($urandom);
        r.imm    = 16'($urandom);
        r.target = 26'($urandom);
        return r;
    endfunction

    // One clock of stimulus: check DUT flags against the model, then advance the model past the edge.
    task automatic cycle(input bit v, input req_t r, input bit ordy, input bit clr,
                         input bit useExp, input logic [31:0] expInstr);
        bit   expRdy;
        bit   acc;
        bit   legal;
        exp_t e;
        bus.in_valid  = v;
        bus.op_sel    = r.op;
        bus.rs        = r.rs;
        bus.rt        = r.rt;
        bus.rd        = r.rd;
        bus.shamt     = r.shamt;
        bus.funct     = r.funct;
        bus.imm       = r.imm;
        bus.target    = r.target;
        bus.out_ready = ordy;
        clear         = clr;
        @(negedge clk);
        expRdy = !clr && !mFull && (mCount < CAP) && (!mPending || ordy);
        check("in_ready", 32'(bus.in_ready), 32'(expRdy));
        check("out_valid", 32'(bus.out_valid), 32'(mPending));
        check("full", 32'(bus.full), 32'(mFull));
        check("err", 32'(bus.err), 32'(mErr));
        acc   = v && expRdy;
        legal = (r.op <= 4'd9);
        mErr  = acc && !legal;
        if (mPending && ordy) mPending = 1'b0;
        if (acc && legal) begin
            e.addr  = AW'(mPtr);
            e.instr = useExp ? expInstr : encode(r);
            expQ.push_back(e);
            mPtr     = (mPtr + 1) % CAP;
            mCount   = mCount + 1;
            mPending = 1'b1;
        end
        if (clr) begin
            mPtr   = 0;
            mCount = 0;
            mFull  = 1'b0;
        end else if (mCount == CAP && !mPending) begin
            mFull = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented word must match the queue head; a handoff retires it.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got addr %h instr %h expected none", bus.out_addr, bus.out_instr);
            end else begin
                check("out_addr", 32'(bus.out_addr), 32'(expQ[0].addr));
                check("out_instr", bus.out_instr, expQ[0].instr);
                if (bus.out_ready) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        req_t r;
        req_t z;
        z = '0;
        bus.in_valid  = 1'b0;
        bus.op_sel    = '0;
        bus.rs        = '0;
        bus.rt        = '0;
        bus.rd        = '0;
        bus.shamt     = '0;
        bus.funct     = '0;
        bus.imm       = '0;
        bus.target    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_addr", 32'(bus.out_addr), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // R-type, then back-to-back words with junk in unused fields.
        r = mkRand(4'd0); r.rs = 5'd1; r.rt = 5'd2; r.rd = 5'd3; r.shamt = 5'd0; r.funct = 6'h20;
        cycle(1, r, 1, 0, 1, 32'h00221820);
        r = mkRand(4'd4); r.rs = 5'd29; r.rt = 5'd8; r.imm = 16'h0004;
        cycle(1, r, 1, 0, 1, 32'h8FA80004);
        r = mkRand(4'd2); r.rs = 5'd1; r.rt = 5'd2; r.imm = 16'hFFFF;
        cycle(1, r, 1, 0, 1, 32'h1022FFFF);
        r = mkRand(4'd1); r.target = 26'h0100000;
        cycle(1, r, 1, 0, 1, 32'h08100000);
        r = mkRand(4'd8); r.rs = 5'd0; r.rt = 5'd5; r.imm = 16'h00FF;
        cycle(1, r, 1, 0, 1, 32'h340500FF);

        // Stall three cycles with a request waiting, then release.
        r = mkRand(4'd7);
        repeat (3) cycle(1, r, 0, 0, 0, 32'd0);
        cycle(1, r, 1, 0, 0, 32'd0);

        // Illegal request between two legal ones.
        cycle(1, mkRand(4'd12), 1, 0, 0, 32'd0);
        cycle(1, mkRand(4'd9), 1, 0, 0, 32'd0);
        cycle(1, mkRand(4'd5), 1, 0, 0, 32'd0);

        // Capacity reached: requests refused, full raised, clear restarts at address 0.
        repeat (3) cycle(1, mkRand(4'd6), 1, 0, 0, 32'd0);
        cycle(1, mkRand(4'd6), 1, 1, 0, 32'd0);
        cycle(1, mkRand(4'd6), 1, 0, 0, 32'd0);
        cycle(0, z, 1, 0, 0, 32'd0);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            cycle($urandom_range(0, 3) != 0, mkRand(op), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 30) == 0, 0, 32'd0);
        end

        // Asynchronous reset with a word stalled at a nonzero address.
        cycle(0, z, 1, 1, 0, 32'd0);
        cycle(0, z, 1, 1, 0, 32'd0);
        cycle(1, mkRand(4'd3), 0, 0, 0, 32'd0);
        cycle(1, mkRand(4'd0), 1, 0, 0, 32'd0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_addr", 32'(bus.out_addr), 32'd0);
        check("arst_out_instr", bus.out_instr, 32'd0);
        expQ.delete();
        mPtr = 0; mCount = 0; mPending = 1'b0; mFull = 1'b0; mErr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1, mkRand(4'd4), 1, 0, 0, 32'd0);
        repeat (3) cycle(0, z, 1, 0, 0, 32'd0);
        check("drained", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
